// File: rtl/pulso_sched.sv
// pulso_sched: round-robin debounce/one-shot scheduler sharing one delay counter among N buttons
module pulso_sched #(
    parameter int N = 4,
    parameter int CW = 18,
    parameter logic [CW-1:0] TERM = 18'h3FFFF
) (
    input  logic                 Clk,
    input  logic                 Clr,
    input  logic [N-1:0]         OP,
    output logic [N-1:0]         Mo,
    output logic                 Busy,
    output logic [$clog2(N)-1:0] Gnt,
    output logic                 Ab
);
    localparam int GW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIRE = 2'd2, HOLD = 2'd3;
    logic [N-1:0] s1_q, s2_q, s3_q, pend_q, pend_d, rise, lvl, gmask, nmask;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sel, idx;
    logic ab_q, ab_d, any;
    // The synchronizer keeps shifting through Clr so a held button reloads s3 and yields no fresh rise
    always_ff @(posedge Clk) begin
        s1_q <= OP;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(ptr_q) + k) % N);
            if (pend_q[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end
    always_comb begin
        rise = s2_q & ~s3_q;
        lvl = s2_q;
        gmask = N'(1) << gnt_q;
        nmask = N'(1) << sel;
        state_d = state_q;
        cnt_d = cnt_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        ab_d = 1'b0;
        pend_d = pend_q | (rise & ~((state_q != IDLE) ? gmask : '0));
        if (state_q == IDLE && any) begin
            state_d = RUN;
            gnt_d = sel;
            cnt_d = '0;
            pend_d = pend_d & ~nmask;
        end else if (state_q == RUN) begin
            if (!lvl[gnt_q]) begin
                ab_d = 1'b1;
                ptr_d = gnt_q;
                state_d = IDLE;
            end else if (cnt_q == TERM) begin
                state_d = FIRE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == FIRE) begin
            ptr_d = gnt_q;
            state_d = HOLD;
        end else if (state_q == HOLD && !lvl[gnt_q]) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            pend_q <= '0;
            cnt_q <= '0;
            gnt_q <= '0;
            ptr_q <= GW'(N - 1);
            ab_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            ab_q <= ab_d;
        end
    end
    assign Mo = (state_q == FIRE) ? gmask : '0;
    assign Busy = state_q != IDLE;
    assign Gnt = gnt_q;
    assign Ab = ab_q;
endmodule
